ddram_bram_responder: RTL and testbench

//  Synthesizable stand-in for ddram_ctrl: responder end of the dc_* DDR request interface.

---
 rtl/ddram_bram_responder.sv | 194 +++++++++++++++++++
 tb/tb_ddram_bram_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_bram_responder.sv
// ddram_bram_responder
//   Synthesizable stand-in for ddram_ctrl. It sits at the responder end of the dc_* DDR request
//   interface and serves read bursts and single-word writes from an on-chip BRAM. The read latency
//   is configurable, so the block can also exercise ack/valid timing corners in upstream logic.
//
// Parameters
//   ADDR_W  word-address bits backing the BRAM (depth = 2**ADDR_W x 64-bit words)
//   RD_LAT  cycles from rd_ack to the first rd_data_valid (0..15); 0 puts beat 0 in the ack cycle
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   rd_addr, rd_burstcnt, rd_req read request (word address, burst length, held until rd_ack)
//   rd_ack                       1-cycle accept pulse
//   rd_data, rd_data_valid       returned burst beats, one valid pulse per word
//   wr_addr, wr_burstcnt         write request address; burst count is ignored (always 1 word)
//   wr_data, wr_be, wr_req       write data, byte enables, request (held until wr_ack)
//   wr_ack, wr_busy              commit pulse, write-in-flight flag
//
// Build option
//   DDRAM_RESP_BE_EN  when defined, writes update only the bytes selected by wr_be;
//                     otherwise every write replaces the whole 64-bit word.

`timescale 1ns/1ps

module ddram_bram_responder #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned RD_LAT = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [28:0] rd_addr,
   input  logic [7:0]  rd_burstcnt,
   input  logic        rd_req,
   output logic        rd_ack,
   output logic [63:0] rd_data,
   output logic        rd_data_valid,
   input  logic [28:0] wr_addr,
   input  logic [7:0]  wr_burstcnt,
   input  logic [63:0] wr_data,
   input  logic [7:0]  wr_be,
   input  logic        wr_req,
   output logic        wr_ack,
   output logic        wr_busy
);

   typedef enum logic [1:0] {StIdle, StRdLat, StRdBurst, StWr} state_t;

   localparam logic [3:0]        LatInit = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0] AddrOne = 1;

   logic [63:0] mem [2**ADDR_W];

   state_t            state;
   logic [ADDR_W-1:0] rd_ptr;      // next word to read
   logic [7:0]        beats_left;  // beats not yet issued to the BRAM
   logic [3:0]        lat_cnt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [63:0]       wr_word;
`ifdef DDRAM_RESP_BE_EN
   logic [7:0]        wr_mask;
`endif

   logic [7:0]        burst_len;
   logic              issue;       // BRAM read this cycle -> valid beat next cycle
   logic [ADDR_W-1:0] issue_addr;
   logic              mem_we;

   logic unused_bits;
`ifdef DDRAM_RESP_BE_EN
   assign unused_bits = ^{rd_addr[28:ADDR_W], wr_addr[28:ADDR_W], wr_burstcnt};
`else
   assign unused_bits = ^{rd_addr[28:ADDR_W], wr_addr[28:ADDR_W], wr_burstcnt, wr_be};
`endif

   always_comb begin
      burst_len  = (rd_burstcnt == 8'd0) ? 8'd1 : rd_burstcnt;
      issue      = 1'b0;
      issue_addr = rd_ptr;
      case (state)
         // Zero latency: beat 0 is fetched on the accept edge so it lands with rd_ack.
         StIdle: begin
            if (rd_req && (RD_LAT == 0)) begin
               issue      = 1'b1;
               issue_addr = rd_addr[ADDR_W-1:0];
            end
         end
         StRdLat:   issue = (lat_cnt == 4'd0);
         StRdBurst: issue = (beats_left != 8'd0);
         default:   issue = 1'b0;
      endcase
      mem_we = (state == StWr) && reset_n;
   end

   // Control FSM. Every burst ends with one StRdBurst cycle holding beats_left == 0, so the
   // FSM is never idle in the rd_ack cycle and a still-high rd_req is not taken twice.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= StIdle;
         rd_ack     <= 1'b0;
         wr_ack     <= 1'b0;
         wr_busy    <= 1'b0;
         lat_cnt    <= 4'd0;
         beats_left <= 8'd0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         wr_word    <= '0;
`ifdef DDRAM_RESP_BE_EN
         wr_mask    <= '0;
`endif
      end else begin
         rd_ack <= 1'b0;
         wr_ack <= 1'b0;
         case (state)
            StIdle: begin
               if (rd_req) begin
                  rd_ack <= 1'b1;
                  if (RD_LAT == 0) begin
                     rd_ptr     <= rd_addr[ADDR_W-1:0] + AddrOne;
                     beats_left <= burst_len - 8'd1;
                     state      <= StRdBurst;
                  end else begin
                     rd_ptr     <= rd_addr[ADDR_W-1:0];
                     beats_left <= burst_len;
                     lat_cnt    <= LatInit;
                     state      <= StRdLat;
                  end
               end else if (wr_req && !wr_ack) begin
                  // wr_ack high means the initiator has not yet seen its ack; ignore the
                  // still-asserted request from that transaction.
                  wr_ptr  <= wr_addr[ADDR_W-1:0];
                  wr_word <= wr_data;
`ifdef DDRAM_RESP_BE_EN
                  wr_mask <= wr_be;
`endif
                  wr_busy <= 1'b1;
                  state   <= StWr;
               end
            end
            StRdLat: begin
               if (lat_cnt == 4'd0) begin
                  rd_ptr     <= rd_ptr + AddrOne;
                  beats_left <= beats_left - 8'd1;
                  state      <= StRdBurst;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            StRdBurst: begin
               if (beats_left != 8'd0) begin
                  rd_ptr     <= rd_ptr + AddrOne;
                  beats_left <= beats_left - 8'd1;
               end else begin
                  state <= StIdle;
               end
            end
            StWr: begin
               wr_ack  <= 1'b1;
               wr_busy <= 1'b0;
               state   <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Registered BRAM read port; valid travels with the data it qualifies.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_data_valid <= 1'b0;
         rd_data       <= '0;
      end else begin
         rd_data_valid <= issue;
         if (issue) begin
            rd_data <= mem[issue_addr];
         end
      end
   end

   // BRAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
`ifdef DDRAM_RESP_BE_EN
         for (int n = 0; n < 8; n++) begin
            if (wr_mask[n]) begin
               mem[wr_ptr][8*n +: 8] <= wr_word[8*n +: 8];
            end
         end
`else
         mem[wr_ptr] <= wr_word;
`endif
      end
   end

endmodule

// File: tb/tb_ddram_bram_responder.sv
`timescale 1ns/1ps

module tb_ddram_bram_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [28:0] rd_addr, wr_addr;
   logic [7:0]  rd_burstcnt, wr_burstcnt, wr_be;
   logic [63:0] wr_data;
   logic        rd_req_a, wr_req_a, rd_req_b, wr_req_b;

   logic        rd_ack_a, rd_valid_a, wr_ack_a, wr_busy_a;
   logic [63:0] rd_data_a;
   logic        rd_ack_b, rd_valid_b, wr_ack_b, wr_busy_b;
   logic [63:0] rd_data_b;

   ddram_bram_responder #(.ADDR_W(12), .RD_LAT(2)) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rd_addr      (rd_addr),
      .rd_burstcnt  (rd_burstcnt),
      .rd_req       (rd_req_a),
      .rd_ack       (rd_ack_a),
      .rd_data      (rd_data_a),
      .rd_data_valid(rd_valid_a),
      .wr_addr      (wr_addr),
      .wr_burstcnt  (wr_burstcnt),
      .wr_data      (wr_data),
      .wr_be        (wr_be),
      .wr_req       (wr_req_a),
      .wr_ack       (wr_ack_a),
      .wr_busy      (wr_busy_a)
   );

   ddram_bram_responder #(.ADDR_W(12), .RD_LAT(0)) u_dut_lat0 (
      .clk          (clk),
      .reset_n      (reset_n),
      .rd_addr      (rd_addr),
      .rd_burstcnt  (rd_burstcnt),
      .rd_req       (rd_req_b),
      .rd_ack       (rd_ack_b),
      .rd_data      (rd_data_b),
      .rd_data_valid(rd_valid_b),
      .wr_addr      (wr_addr),
      .wr_burstcnt  (wr_burstcnt),
      .wr_data      (wr_data),
      .wr_be        (wr_be),
      .wr_req       (wr_req_b),
      .wr_ack       (wr_ack_b),
      .wr_busy      (wr_busy_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] beats [16];
   int ack_at, first_at, last_at, nbeats, nacks;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single-word write on instance a (b=0) or b (b=1); cycle counts are relative to the
   // edge that first samples the request.
   task automatic do_write(input bit b, input logic [28:0] a, input logic [63:0] d,
                           input logic [7:0] be, output int ack_cyc, output int busy_cyc);
      wr_addr = a; wr_data = d; wr_be = be; wr_burstcnt = 8'd1;
      if (b) wr_req_b = 1'b1; else wr_req_a = 1'b1;
      ack_cyc = -1; busy_cyc = -1;
      for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
         step();
         if ((b ? wr_busy_b : wr_busy_a) && busy_cyc < 0) busy_cyc = c;
         if (b ? wr_ack_b : wr_ack_a) begin
            ack_cyc = c;
            wr_req_a = 1'b0; wr_req_b = 1'b0;
         end
      end
      wr_req_a = 1'b0; wr_req_b = 1'b0;
      step();
   endtask

   // Read burst; watches a fixed window so extra or missing beats are counted too.
   task automatic do_read(input bit b, input logic [28:0] a, input logic [7:0] n);
      rd_addr = a; rd_burstcnt = n;
      if (b) rd_req_b = 1'b1; else rd_req_a = 1'b1;
      ack_at = -1; first_at = -1; last_at = -1; nbeats = 0; nacks = 0;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (b ? rd_ack_b : rd_ack_a) begin
            nacks++;
            if (ack_at < 0) ack_at = c;
            rd_req_a = 1'b0; rd_req_b = 1'b0;
         end
         if (b ? rd_valid_b : rd_valid_a) begin
            if (first_at < 0) first_at = c;
            last_at = c;
            if (nbeats < 16) beats[nbeats] = b ? rd_data_b : rd_data_a;
            nbeats++;
         end
      end
      rd_req_a = 1'b0; rd_req_b = 1'b0;
   endtask

   logic [63:0] wrap_data [4];
   logic [28:0] wrap_addr [4];
   logic [63:0] be_exp;
   int ac, bc, wr_ack_at;

   initial begin
      reset_n = 1'b0;
      rd_addr = '0; rd_burstcnt = 8'd1; wr_addr = '0; wr_burstcnt = 8'd1;
      wr_data = '0; wr_be = 8'hFF;
      rd_req_a = 1'b1; wr_req_a = 1'b0; rd_req_b = 1'b0; wr_req_b = 1'b0;

      // 1. Reset with rd_req held high
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_flags", {60'd0, rd_ack_a, rd_valid_a, wr_ack_a, wr_busy_a}, 64'd0);
         check("rst_data", rd_data_a, 64'd0);
      end
      reset_n = 1'b1;
      step();
      check("rst_first_ack", {63'd0, rd_ack_a}, 64'd1);
      rd_req_a = 1'b0;
      repeat (10) step();

      // 2. Write then read back, RD_LAT=2
      do_write(1'b0, 29'h10, 64'h1122334455667788, 8'hFF, ac, bc);
      check("wr_ack_lat", ac, 2);
      check("wr_busy_cyc", bc, 1);
      do_read(1'b0, 29'h10, 8'd1);
      check("rd_ack_at", ack_at, 1);
      check("rd_nacks", nacks, 1);
      check("rd_first_at", first_at, 3);
      check("rd_nbeats", nbeats, 1);
      check("rd_data", beats[0], 64'h1122334455667788);

      // burstcnt 0 is served as a single beat
      do_read(1'b0, 29'h10, 8'd0);
      check("bc0_nbeats", nbeats, 1);
      check("bc0_data", beats[0], 64'h1122334455667788);

      // 3. Address wrap at the top of the array
      wrap_addr[0] = 29'hFFE; wrap_addr[1] = 29'hFFF; wrap_addr[2] = 29'h000; wrap_addr[3] = 29'h001;
      for (int k = 0; k < 4; k++) begin
         wrap_data[k] = 64'hC0DE_0000_0000_0000 | 64'(k + 1);
         do_write(1'b0, wrap_addr[k], wrap_data[k], 8'hFF, ac, bc);
      end
      do_read(1'b0, 29'hFFE, 8'd4);
      check("wrap_first_at", first_at, 3);
      check("wrap_nbeats", nbeats, 4);
      check("wrap_gapless", last_at - first_at, 3);
      for (int k = 0; k < 4; k++) check("wrap_data", beats[k], wrap_data[k]);

      // 4. Zero-latency instance, burst of 3
      for (int k = 0; k < 3; k++) do_write(1'b1, 29'h40 + 29'(k), 64'hB0B0_0000_0000_0000 | 64'(k), 8'hFF, ac, bc);
      do_read(1'b1, 29'h40, 8'd3);
      check("lat0_ack_at", ack_at, 1);
      check("lat0_first_at", first_at, 1);
      check("lat0_nbeats", nbeats, 3);
      check("lat0_last_at", last_at, 3);
      for (int k = 0; k < 3; k++) check("lat0_data", beats[k], 64'hB0B0_0000_0000_0000 | 64'(k));

      // 5. Simultaneous read and write: read first, with pre-write data
      do_write(1'b0, 29'h30, 64'hD1D1_D1D1_D1D1_D1D1, 8'hFF, ac, bc);
      do_write(1'b0, 29'h31, 64'hD3D3_D3D3_D3D3_D3D3, 8'hFF, ac, bc);
      rd_addr = 29'h30; rd_burstcnt = 8'd2;
      wr_addr = 29'h30; wr_data = 64'hD2D2_D2D2_D2D2_D2D2; wr_be = 8'hFF;
      rd_req_a = 1'b1; wr_req_a = 1'b1;
      ack_at = -1; first_at = -1; last_at = -1; nbeats = 0; wr_ack_at = -1;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (rd_ack_a) begin
            if (ack_at < 0) ack_at = c;
            rd_req_a = 1'b0;
         end
         if (rd_valid_a) begin
            if (first_at < 0) first_at = c;
            last_at = c;
            if (nbeats < 16) beats[nbeats] = rd_data_a;
            nbeats++;
         end
         if (wr_ack_a) begin
            if (wr_ack_at < 0) wr_ack_at = c;
            wr_req_a = 1'b0;
         end
      end
      check("coll_rd_ack_at", ack_at, 1);
      check("coll_nbeats", nbeats, 2);
      check("coll_data0", beats[0], 64'hD1D1_D1D1_D1D1_D1D1);
      check("coll_data1", beats[1], 64'hD3D3_D3D3_D3D3_D3D3);
      check("coll_wr_after_rd", {63'd0, (wr_ack_at > last_at) && (last_at > 0)}, 64'd1);
      do_read(1'b0, 29'h30, 8'd1);
      check("coll_new_data", beats[0], 64'hD2D2_D2D2_D2D2_D2D2);

      // 6. Byte-enabled write
      do_write(1'b0, 29'h20, 64'd0, 8'hFF, ac, bc);
      do_read(1'b0, 29'h20, 8'd1);
      check("be_prior", beats[0], 64'd0);
      do_write(1'b0, 29'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, ac, bc);
      check("be_wr_ack_lat", ac, 2);
      do_read(1'b0, 29'h20, 8'd1);
`ifdef DDRAM_RESP_BE_EN
      be_exp = 64'h0000_0000_FFFF_FFFF;
`else
      be_exp = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
      check("be_result", beats[0], be_exp);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
